// File: rtl/pwm_from_count.sv
// pwm_from_count: turns an upstream free-running count into a registered PWM
// output. Duty updates are double buffered and only take effect on a period
// boundary (count wrap), so no output period is ever truncated.
//
// state | meaning
// IDLE  | disabled, output held at idle level
// SYNC  | enabled, waiting for a period boundary before driving output
// RUN   | driving PWM, one full period per count wrap
module pwm_from_count #(
    parameter int unsigned      WIDTH    = 8,
    parameter logic [WIDTH-1:0] DUTY_RST = '0,
    parameter bit               POL      = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] count,
    input  logic             enable,
    input  logic [WIDTH-1:0] duty_in,
    input  logic             duty_valid,
    output logic             duty_ready,
    output logic             pwm_out,
    output logic             period_done,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] active_duty;
    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] active_duty_eff;
    logic             pending_full;
    logic             wrap;
    logic             accept;
    logic             load;
    logic             pwm_d;
    logic             period_done_d;
    logic             busy_d;

    // Any backwards step of the count is a boundary; this also covers an
    // upstream counter reset in the middle of a period.
    assign wrap            = (count < count_q);
    assign duty_ready      = ~pending_full;
    assign accept          = duty_valid & ~pending_full;
    assign load            = wrap & pending_full;
    // The duty promoted on this wrap already governs the count = 0 sample.
    assign active_duty_eff = load ? pending : active_duty;

    // Remember the previous count for wrap detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count;
        end
    end

    // One pending slot, promoted to active on wrap in every state.
    // accept and load are exclusive: accept needs the slot empty, load full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_duty  <= DUTY_RST;
            pending      <= '0;
            pending_full <= 1'b0;
        end else begin
            if (load) begin
                active_duty  <= pending;
                pending_full <= 1'b0;
            end
            if (accept) begin
                pending      <= duty_in;
                pending_full <= 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; a low enable overrides any wrap.
    always_comb begin
        next_state = state;
        if (!enable) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    next_state = SYNC;
                SYNC:    next_state = wrap ? RUN : SYNC;
                RUN:     next_state = RUN;
                default: next_state = IDLE;
            endcase
        end
    end

    // Output decode, looking at the state being entered this cycle.
    always_comb begin
        pwm_d         = ~POL;
        period_done_d = 1'b0;
        busy_d        = (next_state != IDLE);
        if (next_state == RUN && count < active_duty_eff) begin
            pwm_d = POL;
        end
        if ((state == RUN || next_state == RUN) && wrap && enable) begin
            period_done_d = 1'b1;
        end
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_out     <= ~POL;
            period_done <= 1'b0;
            busy        <= 1'b0;
        end else begin
            pwm_out     <= pwm_d;
            period_done <= period_done_d;
            busy        <= busy_d;
        end
    end

endmodule

// File: tb/tb_pwm_from_count.sv
// Testbench for pwm_from_count: directed scenarios plus a randomized run, all
// compared cycle by cycle against a behavioural model of the duty/period rules.
module tb_pwm_from_count;

    localparam bit POL = 1'b1;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] count;
    logic       enable;
    logic [7:0] duty_in;
    logic       duty_valid;
    logic       duty_ready;
    logic       pwm_out;
    logic       period_done;
    logic       busy;

    int checks = 0;
    int errors = 0;

    int send_q[$];

    always #5 clk = ~clk;

    pwm_from_count #(
        .WIDTH   (8),
        .DUTY_RST(8'd0),
        .POL     (POL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .count      (count),
        .enable     (enable),
        .duty_in    (duty_in),
        .duty_valid (duty_valid),
        .duty_ready (duty_ready),
        .pwm_out    (pwm_out),
        .period_done(period_done),
        .busy       (busy)
    );

    // Reference model: running/waiting flags, a one-entry pending slot and
    // the previous count, evaluated with plain arithmetic at every edge.
    bit m_run, m_wait, m_full;
    int m_active, m_pend, m_prev;
    bit e_pwm, e_pd, e_busy;

    always @(posedge clk or posedge rst) begin
        bit wrapped, was_run, acc;
        int duty_now;
        if (rst) begin
            m_run = 0; m_wait = 0; m_full = 0;
            m_active = 0; m_pend = 0; m_prev = 0;
            e_pwm = !POL; e_pd = 0; e_busy = 0;
        end else begin
            wrapped  = (int'(count) < m_prev);
            acc      = duty_valid && !m_full;
            duty_now = (wrapped && m_full) ? m_pend : m_active;
            was_run  = m_run;
            if (!enable) begin
                m_run = 0; m_wait = 0;
            end else if (m_wait && wrapped) begin
                m_wait = 0; m_run = 1;
            end else if (!m_run && !m_wait) begin
                m_wait = 1;
            end
            e_pwm  = (m_run && int'(count) < duty_now) ? POL : !POL;
            e_pd   = (was_run || m_run) && wrapped && enable;
            e_busy = m_run || m_wait;
            if (wrapped && m_full) begin
                m_active = m_pend;
                m_full   = 0;
            end
            if (acc) begin
                m_pend = int'(duty_in);
                m_full = 1;
            end
            m_prev = int'(count);
        end
    end

    logic [3:0] obs, exp_v;
    assign obs   = {pwm_out, period_done, busy, duty_ready};
    assign exp_v = {e_pwm, e_pd, e_busy, !m_full};

    // Valid/ready source: holds the head value until it is taken.
    task automatic drive_duty();
        if (send_q.size() != 0) begin
            duty_valid = 1'b1;
            duty_in    = 8'(send_q[0]);
            if (duty_ready) void'(send_q.pop_front());
        end else begin
            duty_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; duty_valid = 1'b0; duty_in = 8'd0; count = 8'd0;
        @(negedge clk);
        checks++;
        if (obs !== 4'b0001) begin
            errors++;
            $display("FAIL reset_values: got %b expected 0001 (pwm,pd,busy,rdy)", obs);
        end
        @(negedge clk);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL reset_model: got %b expected %b", obs, exp_v);
        end
        rst = 1'b0;
    endtask

    // Duty 0 from reset: never high, pulse every 256 cycles from first wrap.
    task automatic test_duty_zero();
        int pulses = 0, highs = 0;
        enable = 1'b1;
        for (int i = 0; i < 768; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL duty_zero i=%0d count=%0d: got %b expected %b", i, count, obs, exp_v);
            end
            if (i == 0) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_after_enable: got %b expected 1", busy);
                end
            end
            pulses += int'(period_done);
            highs  += int'(pwm_out);
            count = count + 8'd1;
            drive_duty();
        end
        checks++;
        if (pulses != 2 || highs != 0) begin
            errors++;
            $display("FAIL duty_zero_totals: got pulses=%0d highs=%0d expected 2 and 0", pulses, highs);
        end
    endtask

    // Duty 64 offered while count = 100; takes effect at the next wrap.
    task automatic test_load_duty();
        int per = -1;
        int highs[4] = '{0, 0, 0, 0};
        for (int i = 0; i < 1024; i++) begin
            @(negedge clk);
            if (count == 8'd0) per++;
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL load_duty i=%0d count=%0d: got %b expected %b", i, count, obs, exp_v);
            end
            if (per >= 0 && per < 4 && pwm_out) highs[per]++;
            count = count + 8'd1;
            if (per == 0 && count == 8'd100) send_q.push_back(64);
            drive_duty();
        end
        checks++;
        if (highs[0] != 0 || highs[1] != 64 || highs[2] != 64) begin
            errors++;
            $display("FAIL load_duty_highs: got %0d/%0d/%0d expected 0/64/64", highs[0], highs[1], highs[2]);
        end
    endtask

    // 40 then 200 within one period: 200 held off until 40 is promoted.
    task automatic test_back_to_back();
        int per = -1, low_ready0 = 0;
        int highs[4] = '{0, 0, 0, 0};
        for (int i = 0; i < 1024; i++) begin
            @(negedge clk);
            if (count == 8'd0) per++;
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL back_to_back i=%0d count=%0d: got %b expected %b", i, count, obs, exp_v);
            end
            if (per >= 0 && per < 4 && pwm_out) highs[per]++;
            if (per == 0 && !duty_ready) low_ready0++;
            count = count + 8'd1;
            if (per == 0 && count == 8'd10) begin
                send_q.push_back(40);
                send_q.push_back(200);
            end
            drive_duty();
        end
        checks++;
        if (low_ready0 != 246 || highs[0] != 64 || highs[1] != 40 || highs[2] != 200) begin
            errors++;
            $display("FAIL back_to_back_totals: got rdy_low=%0d highs=%0d/%0d/%0d expected 246 64/40/200",
                     low_ready0, highs[0], highs[1], highs[2]);
        end
    endtask

    // Duty 0 then 255: never high, then low exactly once per period.
    task automatic test_boundaries();
        int per = -1;
        int highs[4] = '{0, 0, 0, 0};
        for (int i = 0; i < 1024; i++) begin
            @(negedge clk);
            if (count == 8'd0) per++;
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL boundaries i=%0d count=%0d: got %b expected %b", i, count, obs, exp_v);
            end
            if (per >= 0 && per < 4 && pwm_out) highs[per]++;
            count = count + 8'd1;
            if (per == 0 && count == 8'd10) send_q.push_back(0);
            if (per == 1 && count == 8'd10) send_q.push_back(255);
            drive_duty();
        end
        checks++;
        if (highs[1] != 0 || highs[2] != 255 || highs[3] != 255) begin
            errors++;
            $display("FAIL boundaries_highs: got %0d/%0d/%0d expected 0/255/255", highs[1], highs[2], highs[3]);
        end
    endtask

    // Duty 128, drop enable at count 30, re-enable at 50.
    task automatic test_disable();
        int per = -1;
        int highs[4] = '{0, 0, 0, 0};
        for (int i = 0; i < 1024; i++) begin
            @(negedge clk);
            if (count == 8'd0) per++;
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL disable i=%0d count=%0d: got %b expected %b", i, count, obs, exp_v);
            end
            if (per == 1 && count == 8'd30) begin
                checks++;
                if (pwm_out !== 1'b0 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL disable_next_cycle: got pwm=%b busy=%b expected 0 0", pwm_out, busy);
                end
            end
            if (per >= 0 && per < 4 && pwm_out) highs[per]++;
            count = count + 8'd1;
            if (per == 0 && count == 8'd10) send_q.push_back(128);
            if (per == 1 && count == 8'd30) enable = 1'b0;
            if (per == 1 && count == 8'd50) enable = 1'b1;
            drive_duty();
        end
        checks++;
        if (highs[1] != 30 || highs[2] != 128) begin
            errors++;
            $display("FAIL disable_highs: got %0d/%0d expected 30/128", highs[1], highs[2]);
        end
    endtask

    // Upstream counter reset at 77 acts as a wrap; async rst drops pending.
    task automatic test_counter_reset();
        int per = -1, highs_after = 0;
        bit did_jump = 0, reached = 0;
        int highs[4] = '{0, 0, 0, 0};
        for (int i = 0; i < 1024 && !reached; i++) begin
            @(negedge clk);
            if (count == 8'd0) per++;
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL counter_reset i=%0d count=%0d: got %b expected %b", i, count, obs, exp_v);
            end
            if (per == 1 && count == 8'd0 && did_jump && highs[1] == 0) begin
                checks++;
                if (period_done !== 1'b1 || duty_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL counter_reset_wrap: got pd=%b rdy=%b expected 1 1", period_done, duty_ready);
                end
            end
            if (per >= 0 && per < 4 && pwm_out) highs[per]++;
            if (per == 2 && count == 8'd100) begin
                reached = 1;
            end else begin
                count = count + 8'd1;
                if (per == 0 && count == 8'd78 && !did_jump) begin
                    count    = 8'd0;
                    did_jump = 1;
                end
                if (per == 0 && count == 8'd20) send_q.push_back(90);
                if (per == 2 && count == 8'd20) send_q.push_back(33);
                drive_duty();
            end
        end
        checks++;
        if (!reached || highs[0] != 78 || highs[1] != 90) begin
            errors++;
            $display("FAIL counter_reset_highs: got reached=%0d highs=%0d/%0d expected 1 78/90",
                     reached, highs[0], highs[1]);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (obs !== 4'b0001) begin
            errors++;
            $display("FAIL async_rst: got %b expected 0001 (pwm,pd,busy,rdy)", obs);
        end
        @(negedge clk);
        rst = 1'b0;
        count = 8'd0;
        send_q.delete();
        duty_valid = 1'b0;
        for (int i = 0; i < 512; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL after_rst i=%0d count=%0d: got %b expected %b", i, count, obs, exp_v);
            end
            highs_after += int'(pwm_out);
            count = count + 8'd1;
            drive_duty();
        end
        checks++;
        if (highs_after != 0) begin
            errors++;
            $display("FAIL pending_lost: got highs=%0d expected 0", highs_after);
        end
    endtask

    // Random counter steps, enables, duty writes and occasional resets.
    task automatic test_random();
        int r;
        enable = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL random i=%0d count=%0d en=%b: got %b expected %b", i, count, enable, obs, exp_v);
            end
            rst = 1'b0;
            r = int'($urandom_range(0, 99));
            if (r < 2)       count = 8'd0;
            else if (r < 4)  count = count;
            else if (r < 5)  count = 8'($urandom_range(0, 255));
            else             count = count + 8'd1;
            if ($urandom_range(0, 199) == 0) enable = !enable;
            if (send_q.size() == 0 && $urandom_range(0, 63) == 0) begin
                r = int'($urandom_range(0, 9));
                send_q.push_back(r == 0 ? 0 : (r == 1 ? 255 : int'($urandom_range(0, 255))));
            end
            drive_duty();
            if ($urandom_range(0, 999) == 0) rst = 1'b1;
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_duty_zero();
        test_load_duty();
        test_back_to_back();
        test_boundaries();
        test_disable();
        test_counter_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
